// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor: diff = a - b, one bit per clock, LSB first.
// Latency: start accepted at edge E0 -> done pulse after edge E0+WIDTH -> ready again after E0+WIDTH+1.
// Backpressure: start is only taken while ready=1; a start seen while busy is dropped, never queued.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow,
  output logic             zero,
  output logic             negative,
  output logic             overflow
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] r_sh;
  logic [CW-1:0]    cnt;
  logic             br;
  // Operand sign bits are kept aside: the shift registers lose them before the flags are formed.
  logic             a_msb;
  logic             b_msb;

  logic             a_i;
  logic             b_i;
  logic             d_bit;
  logic             br_nxt;
  logic [WIDTH-1:0] res_full;

  // One full-subtractor cell on the current LSBs plus the result as it looks once this bit lands.
  always_comb begin
    a_i      = a_sh[0];
    b_i      = b_sh[0];
    d_bit    = a_i ^ b_i ^ br;
    br_nxt   = (~a_i & b_i) | (~(a_i ^ b_i) & br);
    res_full = {d_bit, r_sh[WIDTH-1:1]};
  end

  // Control FSM and datapath; diff/flags only load on the final RUN edge so partial results never show.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      a_sh     <= '0;
      b_sh     <= '0;
      r_sh     <= '0;
      cnt      <= '0;
      br       <= 1'b0;
      a_msb    <= 1'b0;
      b_msb    <= 1'b0;
      diff     <= '0;
      borrow   <= 1'b0;
      zero     <= 1'b0;
      negative <= 1'b0;
      overflow <= 1'b0;
      done     <= 1'b0;
      busy     <= 1'b0;
      ready    <= 1'b1;
    end else begin
      case (state)
        S_IDLE: begin
          done <= 1'b0;
          if (start) begin
            a_sh  <= a;
            b_sh  <= b;
            a_msb <= a[WIDTH-1];
            b_msb <= b[WIDTH-1];
            br    <= 1'b0;
            cnt   <= '0;
            state <= S_RUN;
            ready <= 1'b0;
            busy  <= 1'b1;
          end
        end
        S_RUN: begin
          a_sh <= a_sh >> 1;
          b_sh <= b_sh >> 1;
          r_sh <= res_full;
          br   <= br_nxt;
          cnt  <= cnt + CW'(1);
          if (cnt == LAST) begin
            state    <= S_DONE;
            done     <= 1'b1;
            diff     <= res_full;
            borrow   <= br_nxt;
            zero     <= (res_full == '0);
            negative <= res_full[WIDTH-1];
            overflow <= (a_msb != b_msb) && (res_full[WIDTH-1] != a_msb);
          end
        end
        S_DONE: begin
          state <= S_IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
          ready <= 1'b1;
        end
        default: begin
          state <= S_IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
          ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Bench for serial_subtractor: scoreboard of expected results, compared on each done pulse.
// Latency: outputs sampled on the falling edge, inputs driven away from the rising edge.
// Backpressure: covers ignored start while busy, start held high, and reset mid-operation.
module tb_serial_subtractor;

  localparam int W = 8;

  typedef struct packed {
    logic [W-1:0] diff;
    logic         borrow;
    logic         zero;
    logic         negative;
    logic         overflow;
  } res_t;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         ready;
  logic         busy;
  logic         done;
  logic [W-1:0] diff;
  logic         borrow;
  logic         zero;
  logic         negative;
  logic         overflow;

  int   errors = 0;
  int   checks = 0;
  res_t sb[$];

  serial_subtractor #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .a        (a),
    .b        (b),
    .ready    (ready),
    .busy     (busy),
    .done     (done),
    .diff     (diff),
    .borrow   (borrow),
    .zero     (zero),
    .negative (negative),
    .overflow (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic res_t model(input logic [W-1:0] x, input logic [W-1:0] y);
    logic [W-1:0] d;
    d = x - y;
    return {d, (x < y), (d == '0), d[W-1], ((x[W-1] != y[W-1]) && (d[W-1] != x[W-1]))};
  endfunction

  function automatic res_t outs();
    return {diff, borrow, zero, negative, overflow};
  endfunction

  // Drive one start pulse; it is accepted on the next rising edge.
  task automatic start_op(input logic [W-1:0] x, input logic [W-1:0] y);
    @(posedge clk); #1;
    a = x; b = y; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Wait (bounded) for a done pulse, counting falling edges.
  task automatic wait_done(input int budget, output bit seen, output res_t r, output int n);
    seen = 1'b0; n = 0; r = '0;
    while (!seen && n < budget) begin
      @(negedge clk);
      n++;
      if (done === 1'b1) begin
        seen = 1'b1;
        r = outs();
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; a = '0; b = '0;
    repeat (2) @(negedge clk);
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", ready); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
    checks++; if (outs() !== res_t'(0)) begin errors++; $display("FAIL reset_result: got %h want 0", outs()); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_arith();
    logic [W-1:0] ta [5] = '{8'd5, 8'd3, 8'h80, 8'h7F, 8'hA5};
    logic [W-1:0] tb [5] = '{8'd3, 8'd5, 8'h01, 8'hFF, 8'h00};
    logic [W-1:0] td [5] = '{8'h02, 8'hFE, 8'h7F, 8'h80, 8'hA5};
    bit   seen;
    res_t got, exp;
    int   n;
    for (int i = 0; i < 5; i++) begin
      sb.push_back(model(ta[i], tb[i]));
      start_op(ta[i], tb[i]);
      wait_done(30, seen, got, n);
      exp = sb.pop_front();
      checks++;
      if (!seen) begin
        errors++; $display("FAIL arith%0d_timeout: got no done want done", i);
      end else begin
        if (got !== exp) begin errors++; $display("FAIL arith%0d_result: got %h want %h", i, got, exp); end
        checks++; if (got.diff !== td[i]) begin errors++; $display("FAIL arith%0d_diff: got %h want %h", i, got.diff, td[i]); end
        checks++; if (n !== W + 1) begin errors++; $display("FAIL arith%0d_latency: got %0d want %0d", i, n, W + 1); end
        checks++; if ({ready, busy} !== 2'b01) begin errors++; $display("FAIL arith%0d_busy_in_done: got %b want 01", i, {ready, busy}); end
        @(negedge clk);
        checks++; if ({ready, busy, done} !== 3'b100) begin errors++; $display("FAIL arith%0d_idle: got %b want 100", i, {ready, busy, done}); end
      end
    end
  endtask

  task automatic test_hold_and_equal();
    res_t held, got, exp;
    bit   stable, seen;
    int   n;
    held = outs();
    stable = 1'b1; seen = 1'b0; n = 0;
    sb.push_back(model(8'h3C, 8'h3C));
    start_op(8'h3C, 8'h3C);
    a = 8'hC3; b = 8'h11;
    while (!seen && n < 30) begin
      @(negedge clk);
      n++;
      if (done === 1'b1) begin
        seen = 1'b1;
        got = outs();
      end else if (outs() !== held) begin
        stable = 1'b0;
      end
    end
    exp = sb.pop_front();
    checks++; if (!stable) begin errors++; $display("FAIL hold_during_run: got changed want %h held", held); end
    checks++;
    if (!seen) begin
      errors++; $display("FAIL equal_timeout: got no done want done");
    end else begin
      if (got !== exp) begin errors++; $display("FAIL equal_result: got %h want %h", got, exp); end
      checks++; if ({got.diff, got.zero, got.borrow} !== {8'h00, 1'b1, 1'b0}) begin
        errors++; $display("FAIL equal_flags: got %h want 00/1/0", {got.diff, got.zero, got.borrow});
      end
    end
  endtask

  task automatic test_ignore_start();
    bit   seen;
    res_t got, exp;
    int   n, extra;
    sb.push_back(model(8'h10, 8'h01));
    start_op(8'h10, 8'h01);
    repeat (3) @(negedge clk);
    a = 8'hFF; b = 8'h00; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(30, seen, got, n);
    exp = sb.pop_front();
    checks++;
    if (!seen) begin
      errors++; $display("FAIL ignore_timeout: got no done want done");
    end else begin
      if (got !== exp) begin errors++; $display("FAIL ignore_result: got %h want %h", got, exp); end
      checks++; if (got.diff !== 8'h0F) begin errors++; $display("FAIL ignore_diff: got %h want 0f", got.diff); end
    end
    extra = 0;
    repeat (15) begin @(negedge clk); if (done === 1'b1) extra++; end
    checks++; if (extra !== 0) begin errors++; $display("FAIL ignore_no_second: got %0d dones want 0", extra); end
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL ignore_ready: got %b want 1", ready); end
  endtask

  task automatic test_abort();
    int extra;
    start_op(8'h55, 8'h22);
    repeat (4) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    checks++; if ({ready, busy, done} !== 3'b100) begin errors++; $display("FAIL abort_ctrl: got %b want 100", {ready, busy, done}); end
    checks++; if (outs() !== res_t'(0)) begin errors++; $display("FAIL abort_result: got %h want 0", outs()); end
    @(negedge clk);
    rst_n = 1'b1;
    extra = 0;
    repeat (15) begin @(negedge clk); if (done === 1'b1) extra++; end
    checks++; if (extra !== 0) begin errors++; $display("FAIL abort_no_done: got %0d dones want 0", extra); end
    checks++; if (outs() !== res_t'(0)) begin errors++; $display("FAIL abort_after: got %h want 0", outs()); end
  endtask

  task automatic test_back_to_back();
    bit   seen;
    res_t got, exp;
    int   n, extra;
    @(negedge clk);
    a = 8'd200; b = 8'd100; start = 1'b1;
    for (int k = 0; k < 4; k++) begin
      sb.push_back(model(8'd200, 8'd100));
      wait_done(30, seen, got, n);
      if (k == 3) start = 1'b0;
      exp = sb.pop_front();
      checks++;
      if (!seen) begin
        errors++; $display("FAIL b2b%0d_timeout: got no done want done", k);
      end else begin
        if (got !== exp) begin errors++; $display("FAIL b2b%0d_result: got %h want %h", k, got, exp); end
        checks++; if ({got.diff, got.borrow} !== {8'd100, 1'b0}) begin
          errors++; $display("FAIL b2b%0d_diff: got %h want 64/0", k, {got.diff, got.borrow});
        end
        if (k > 0) begin
          checks++; if (n !== W + 2) begin errors++; $display("FAIL b2b%0d_period: got %0d want %0d", k, n, W + 2); end
        end
      end
    end
    extra = 0;
    repeat (12) begin @(negedge clk); if (done === 1'b1) extra++; end
    checks++; if (extra !== 0) begin errors++; $display("FAIL b2b_stop: got %0d dones want 0", extra); end
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL b2b_ready: got %b want 1", ready); end
  endtask

  initial begin
    test_reset();
    test_arith();
    test_hold_and_equal();
    test_ignore_start();
    test_abort();
    test_back_to_back();
    checks++; if (sb.size() !== 0) begin errors++; $display("FAIL scoreboard_empty: got %0d left want 0", sb.size()); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
